// File: rtl/onehot_reg_file.sv
// onehot_reg_file: eight-entry register bank written through a one-hot select,
// with two registered read ports, write-through bypass and malformed-select flagging.
module onehot_reg_file #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [7:0]       wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [2:0]       rd_addr_a,
    input  logic [2:0]       rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             sel_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] wr_count
);
    logic [WIDTH-1:0] regs [8];
    logic             wr_ok;
    logic             wr_bad;
    assign wr_ok  = wr_en && $onehot(wr_sel);
    assign wr_bad = wr_en && !$onehot(wr_sel);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            rd_data_a  <= '0;
            rd_data_b  <= '0;
            sel_err    <= 1'b0;
            err_sticky <= 1'b0;
            wr_count   <= '0;
        end else begin
            for (int i = 0; i < 8; i++) if (wr_ok && wr_sel[i]) regs[i] <= wr_data;
            // a same-cycle accepted write to the addressed register wins over stored contents
            rd_data_a  <= (wr_ok && wr_sel[rd_addr_a]) ? wr_data : regs[rd_addr_a];
            rd_data_b  <= (wr_ok && wr_sel[rd_addr_b]) ? wr_data : regs[rd_addr_b];
            sel_err    <= wr_bad;
            err_sticky <= err_sticky | wr_bad;
            if (wr_ok) wr_count <= wr_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_onehot_reg_file.sv
// tb_onehot_reg_file: directed self-checking bench for onehot_reg_file.
module tb_onehot_reg_file;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_sel;
    logic [7:0] wr_data;
    logic [2:0] rd_addr_a;
    logic [2:0] rd_addr_b;
    logic [7:0] rd_data_a;
    logic [7:0] rd_data_b;
    logic       sel_err;
    logic       err_sticky;
    logic [7:0] wr_count;
    int         n_cmp = 0;
    int         n_err = 0;

    onehot_reg_file #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a),
        .rd_data_b(rd_data_b), .sel_err(sel_err), .err_sticky(err_sticky), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] sel, input logic [7:0] data);
        wr_en = 1'b1;
        wr_sel = sel;
        wr_data = data;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
        step();
        step();
        chk("rst_rda", rd_data_a, 8'h00);
        chk("rst_sticky", 8'(err_sticky), 8'h00);
        rst_n = 1'b1;
        wr(8'h01, 8'h77);
        step();
        chk("pre_rda", rd_data_a, 8'h77);
        chk("pre_cnt", wr_count, 8'h01);
        // async reset mid-cycle with a pending write that must be ignored
        #3;
        rst_n = 1'b0; wr_en = 1'b1; wr_sel = 8'h02; wr_data = 8'h99;
        #1;
        chk("arst_rda", rd_data_a, 8'h00);
        chk("arst_cnt", wr_count, 8'h00);
        chk("arst_err", 8'(sel_err), 8'h00);
        step();
        wr_en = 1'b0;
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            rd_addr_b = 3'(7 - i);
            step();
            chk("rst_read_a", rd_data_a, 8'h00);
            chk("rst_read_b", rd_data_b, 8'h00);
        end
        chk("rst_cnt2", wr_count, 8'h00);
        // basic write then read on both ports
        wr(8'b0000_1000, 8'hA5);
        rd_addr_a = 3'd3; rd_addr_b = 3'd3;
        step();
        chk("basic_a", rd_data_a, 8'hA5);
        chk("basic_b", rd_data_b, 8'hA5);
        chk("basic_cnt", wr_count, 8'h01);
        // bypass on port A while port B reads stored reg2
        wr(8'b0000_0100, 8'h11);
        rd_addr_a = 3'd5; rd_addr_b = 3'd2;
        wr(8'b0010_0000, 8'h3C);
        chk("byp_a", rd_data_a, 8'h3C);
        chk("byp_b", rd_data_b, 8'h11);
        rd_addr_a = 3'd6; rd_addr_b = 3'd6;
        wr(8'b0100_0000, 8'h5A);
        chk("byp2_a", rd_data_a, 8'h5A);
        chk("byp2_b", rd_data_b, 8'h5A);
        chk("byp_cnt", wr_count, 8'h04);
        // fill, then reject two malformed selects back to back
        for (int i = 0; i < 8; i++) wr(8'(1 << i), 8'(i * 16));
        chk("fill_cnt", wr_count, 8'h0C);
        chk("fill_err", 8'(sel_err), 8'h00);
        wr_en = 1'b1; wr_sel = 8'b0001_0001; wr_data = 8'hFF;
        step();
        chk("bad1_err", 8'(sel_err), 8'h01);
        chk("bad1_sticky", 8'(err_sticky), 8'h01);
        wr_sel = 8'h00;
        step();
        chk("bad2_err", 8'(sel_err), 8'h01);
        wr_en = 1'b0;
        step();
        chk("bad_end_err", 8'(sel_err), 8'h00);
        chk("bad_sticky", 8'(err_sticky), 8'h01);
        chk("bad_cnt", wr_count, 8'h0C);
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            rd_addr_b = 3'((i + 1) % 8);
            step();
            chk("bad_read_a", rd_data_a, 8'(i * 16));
            chk("bad_read_b", rd_data_b, 8'(((i + 1) % 8) * 16));
        end
        // wr_en low: select ignored entirely
        wr_en = 1'b0; wr_sel = 8'hFF; wr_data = 8'hEE; rd_addr_a = 3'd4; rd_addr_b = 3'd7;
        step();
        step();
        chk("ign_err", 8'(sel_err), 8'h00);
        chk("ign_cnt", wr_count, 8'h0C);
        chk("ign_a", rd_data_a, 8'h40);
        chk("ign_b", rd_data_b, 8'h70);
        // counter wrap from a clean reset
        #3;
        rst_n = 1'b0;
        #1;
        chk("wrap_rst_sticky", 8'(err_sticky), 8'h00);
        #2;
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 255; k++) wr(8'(1 << (k % 8)), 8'(k));
        chk("wrap_255", wr_count, 8'hFF);
        wr(8'h80, 8'hAB);
        chk("wrap_0", wr_count, 8'h00);
        wr(8'h01, 8'hCD);
        chk("wrap_1", wr_count, 8'h01);
        chk("wrap_sticky", 8'(err_sticky), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
